// File: rtl/shot_responder.sv
// ---------------------------------------------------------------------------
// shot_responder
//
// Defending-side end of the shot exchange between the two boards. The
// opponent sends a shot address {row[7:4], col[3:0]} over the UART link.
// This block looks the address up in the local ship map, marks the cell,
// returns a one-byte result to the opponent and tells the local game FSM
// what happened so it can hand the turn over.
//
// Result byte codes returned on tx_data:
//   0x00 miss, 0x01 hit, 0x02 repeat shot, 0x03 hit that sank the last ship,
//   0xEE address outside the board.
//
// Ship-map cell codes:
//   00 empty, 01 ship, 10 ship hit, 11 water shot
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   enable          local FSM is waiting for an incoming shot
//   rx_data/valid   received shot address byte and its one-cycle strobe
//   board_rd_addr   ship-map read address (RAM has one cycle read latency)
//   board_rd_data   cell code read back from the ship map
//   board_wr_*      ship-map write port (one-cycle strobe)
//   tx_data/valid   result byte towards the UART transmitter
//   tx_ready        transmitter accepts the byte when tx_valid & tx_ready
//   msg_send        00 none, 01 miss, 10 hit, 11 all sunk; held until msg_clr
//   msg_clr         one-cycle pulse from the game FSM that clears msg_send
//   check_in        last accepted shot address, for the display
//   hit_count       hits taken so far, saturating at SHIP_CELLS
//   all_sunk        sticky, every ship cell has been hit
//   overrun         sticky, a shot byte arrived when it could not be served
//   busy            a shot is being processed
// ---------------------------------------------------------------------------
module shot_responder #(
    parameter int BOARD_DIM  = 10,
    parameter int SHIP_CELLS = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] board_rd_addr,
    input  logic [1:0] board_rd_data,
    output logic       board_wr_en,
    output logic [7:0] board_wr_addr,
    output logic [1:0] board_wr_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [1:0] msg_send,
    input  logic       msg_clr,
    output logic [7:0] check_in,
    output logic [3:0] hit_count,
    output logic       all_sunk,
    output logic       overrun,
    output logic       busy
);

    // Board limit widened by one bit so a 16-wide board still compares
    // correctly against a 4-bit row or column.
    localparam logic [4:0] DIM_LIMIT = 5'(BOARD_DIM);
    localparam logic [3:0] SHIP_MAX  = 4'(SHIP_CELLS);

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_SHIP  = 2'b01;
    localparam logic [1:0] CELL_HIT   = 2'b10;
    localparam logic [1:0] CELL_WATER = 2'b11;

    localparam logic [1:0] MSG_NONE = 2'b00;
    localparam logic [1:0] MSG_MISS = 2'b01;
    localparam logic [1:0] MSG_HIT  = 2'b10;
    localparam logic [1:0] MSG_SUNK = 2'b11;

    localparam logic [7:0] REPLY_MISS    = 8'h00;
    localparam logic [7:0] REPLY_HIT     = 8'h01;
    localparam logic [7:0] REPLY_REPEAT  = 8'h02;
    localparam logic [7:0] REPLY_SUNK    = 8'h03;
    localparam logic [7:0] REPLY_INVALID = 8'hEE;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EVAL,
        WRITE,
        SEND
    } state_t;

    state_t state;
    state_t next_state;

    logic [7:0] addr;
    logic [1:0] wr_code;
    logic [1:0] result;
    logic       load_msg;
    logic       accept_shot;
    logic       shot_invalid;
    logic       handshake;
    logic       ignored_shot;
    logic [3:0] count_next;

    // A shot is only taken when the local FSM is waiting for one, the
    // previous result has been consumed and the game is still running.
    assign accept_shot  = (state == IDLE) && rx_valid && enable &&
                          (msg_send == MSG_NONE) && !all_sunk;

    // Row and column are checked independently; either one out of range
    // makes the whole shot invalid.
    assign shot_invalid = ({1'b0, rx_data[7:4]} >= DIM_LIMIT) ||
                          ({1'b0, rx_data[3:0]} >= DIM_LIMIT);

    assign handshake    = (state == SEND) && tx_ready;

    // A byte that arrives while a shot is in flight, or while the game
    // cannot take a new shot even though the FSM is listening, is lost and
    // flagged. A byte arriving while the FSM is not listening is simply
    // not our business and is dropped without a flag.
    assign ignored_shot = rx_valid &&
                          ((state != IDLE) ||
                           (enable && ((msg_send != MSG_NONE) || all_sunk)));

    // Hit counter never wraps past the number of ship cells.
    assign count_next   = (hit_count == SHIP_MAX) ? hit_count : hit_count + 4'd1;

    assign board_wr_addr = addr;
    assign board_wr_data = wr_code;

    // State register. Reset drops straight back to IDLE from anywhere,
    // which also removes tx_valid and board_wr_en on the same clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Out-of-range shots go straight to SEND to report
    // the error without touching the map; repeat shots skip WRITE because
    // the cell already carries its final code. Enable falling mid-shot
    // does not abort the sequence.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept_shot) begin
                    next_state = shot_invalid ? SEND : READ;
                end
            end
            READ: begin
                next_state = EVAL;
            end
            EVAL: begin
                next_state = board_rd_data[1] ? SEND : WRITE;
            end
            WRITE: begin
                next_state = SEND;
            end
            SEND: begin
                if (tx_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode. The write strobe and the TX valid come straight from
    // the state so each lasts exactly as long as its state does.
    always_comb begin
        tx_valid    = 1'b0;
        board_wr_en = 1'b0;
        busy        = 1'b1;
        case (state)
            IDLE:    busy        = 1'b0;
            WRITE:   board_wr_en = 1'b1;
            SEND:    tx_valid    = 1'b1;
            default: busy        = 1'b1;
        endcase
    end

    // Shot datapath. The address is captured on acceptance and the RAM read
    // address is only moved for in-range shots, so an invalid shot leaves
    // the map interface untouched. In EVAL the cell code read back decides
    // the new cell code, the reply byte and the result for the game FSM;
    // the reply stays registered so tx_data is stable under back-pressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr          <= '0;
            check_in      <= '0;
            board_rd_addr <= '0;
            tx_data       <= '0;
            wr_code       <= '0;
            result        <= '0;
            load_msg      <= 1'b0;
            hit_count     <= '0;
            all_sunk      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_shot) begin
                        addr     <= rx_data;
                        check_in <= rx_data;
                        if (shot_invalid) begin
                            tx_data  <= REPLY_INVALID;
                            load_msg <= 1'b0;
                        end else begin
                            board_rd_addr <= rx_data;
                        end
                    end
                end
                EVAL: begin
                    load_msg <= 1'b1;
                    case (board_rd_data)
                        CELL_EMPTY: begin
                            wr_code <= CELL_WATER;
                            tx_data <= REPLY_MISS;
                            result  <= MSG_MISS;
                        end
                        CELL_SHIP: begin
                            wr_code   <= CELL_HIT;
                            hit_count <= count_next;
                            if (count_next == SHIP_MAX) begin
                                tx_data  <= REPLY_SUNK;
                                result   <= MSG_SUNK;
                                all_sunk <= 1'b1;
                            end else begin
                                tx_data <= REPLY_HIT;
                                result  <= MSG_HIT;
                            end
                        end
                        default: begin
                            tx_data <= REPLY_REPEAT;
                            result  <= MSG_MISS;
                        end
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

    // Result message towards the game FSM. A result arriving on the same
    // cycle as a clear wins, so a clear meant for the previous message can
    // never wipe out the new one. Invalid shots never load a result.
    always_ff @(posedge clk) begin
        if (rst) begin
            msg_send <= MSG_NONE;
        end else if (handshake && load_msg) begin
            msg_send <= result;
        end else if (msg_clr) begin
            msg_send <= MSG_NONE;
        end
    end

    // Overrun flag is sticky until reset so a lost shot is never missed by
    // whoever looks at it later.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (ignored_shot) begin
            overrun <= 1'b1;
        end
    end

endmodule
